// File: rtl/mmio_uart_tx.sv
`timescale 1ns/1ps
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-low reset
//   MemWrite  - processor store strobe
//   DataAdr   - processor data address
//   WriteData - processor store data
//   ReadData  - combinational register read data (TXDATA reads 0, STATUS)
//   tx        - serial line, idle high
//   tx_busy   - frame in progress or bytes queued
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        tx_busy
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          BW        = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0] FULL      = (PW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST    = BW'(CLKS_PER_BIT - 1);
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic [7:0]    shreg;
    logic [2:0]    idx;
    logic [BW-1:0] baud;
    logic          overflow;
    logic          sel_data, sel_stat, push_req, push, pop, ovf_clr;
    logic          bit_end, full, empty, active;
    logic          unused_wd;

    assign sel_data = DataAdr == BASE_ADDR;
    assign sel_stat = DataAdr == STAT_ADDR;
    assign push_req = MemWrite && sel_data;
    assign ovf_clr  = MemWrite && sel_stat && WriteData[3];
    assign full     = count == FULL;
    assign empty    = count == '0;
    assign active   = state != IDLE;
    assign bit_end  = baud == '0;
    // The FSM takes a byte when idle, or at the end of a stop bit so frames abut.
    assign pop      = !empty && (state == IDLE || (state == STOP && bit_end));
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign push     = push_req && (!full || pop);
    assign tx_busy  = active || !empty;
    assign ReadData = sel_stat ? {24'h0, 4'(count), overflow, active, empty, full} : 32'h0;
    assign unused_wd = ^WriteData[31:8];

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= WriteData[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) count <= count + (PW+1)'(1);
            else if (pop && !push) count <= count - (PW+1)'(1);
            if (push_req && !push) overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            tx    <= 1'b1;
            shreg <= '0;
            idx   <= '0;
            baud  <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    state <= START;
                    tx    <= 1'b0;
                    shreg <= mem[rd_ptr];
                    baud  <= LAST;
                end
                START: if (bit_end) begin
                    state <= DATA;
                    tx    <= shreg[0];
                    idx   <= '0;
                    baud  <= LAST;
                end else baud <= baud - BW'(1);
                DATA: if (bit_end) begin
                    baud <= LAST;
                    if (idx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        shreg <= shreg >> 1;
                        tx    <= shreg[1];
                        idx   <= idx + 3'd1;
                    end
                end else baud <= baud - BW'(1);
                STOP: if (bit_end) begin
                    if (pop) begin
                        state <= START;
                        tx    <= 1'b0;
                        shreg <= mem[rd_ptr];
                        baud  <= LAST;
                    end else begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                end else baud <= baud - BW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx (4 clocks/bit, depth 4).
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam logic [31:0] STAT = 32'h0000_0404;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        tx;
    logic        tx_busy;

    int          tests = 0;
    int          fails = 0;
    int          bad;
    logic [39:0] fr;
    logic [39:0] e;
    logic [7:0]  pat [10] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h3C, 8'hC3};

    mmio_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        DataAdr = a;
        WriteData = d;
        step();
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        DataAdr = a;
        #1;
    endtask

    // Sample tx once per cycle from frame cycle 'start' through cycle 39.
    task automatic cap(input int start);
        for (int i = start; i < 40; i++) begin
            fr[i] = tx;
            step();
        end
    endtask

    // Expected per-cycle line pattern for one frame: start, 8 data LSB first, stop.
    function automatic logic [39:0] ef(input logic [7:0] b);
        logic [9:0]  f;
        logic [39:0] r;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) r[i] = f[i/4];
        return r;
    endfunction

    initial begin
        DataAdr = STAT;
        step();
        step();
        chk("reset_status", ReadData, 64'h2);
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        reset = 1'b1;
        bad = 0;
        repeat (50) begin
            step();
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("idle_50_bad_cycles", bad, 0);
        chk("idle_status", ReadData, 64'h2);

        wr(BASE + 32'd8, 32'hAB);
        step();
        chk("unmapped_write_busy", tx_busy, 0);
        rd(BASE + 32'd8);
        chk("unmapped_read", ReadData, 0);
        rd(BASE);
        chk("txdata_read", ReadData, 0);

        wr(BASE, 32'hFFFF_FF55);
        chk("single_busy_after_write", tx_busy, 1);
        chk("single_tx_before_pop", tx, 1);
        step();
        cap(0);
        chk("single_frame_55", fr, 40'hF0F0F0F0F0);
        chk("single_busy_after", tx_busy, 0);

        wr(BASE, 32'h41);
        wr(BASE, 32'h42);
        fr[0] = tx;
        wr(BASE, 32'h43);
        rd(STAT);
        chk("b2b_status_count2", ReadData, 64'h24);
        cap(1);
        chk("b2b_frame_41", fr, ef(8'h41));
        cap(0);
        chk("b2b_frame_42", fr, ef(8'h42));
        cap(0);
        chk("b2b_frame_43", fr, ef(8'h43));
        chk("b2b_busy_after", tx_busy, 0);

        for (int i = 0; i < 6; i++) wr(BASE, 32'h10 + i);
        rd(STAT);
        chk("ovf_status_full_ovf", ReadData, 64'h4D);
        cap(4);
        e = ef(8'h10);
        chk("ovf_frame_10_tail", fr[39:4], e[39:4]);
        for (int i = 1; i < 5; i++) begin
            cap(0);
            chk($sformatf("ovf_frame_%0h", 8'h10 + i), fr, ef(8'(8'h10 + i)));
        end
        bad = 0;
        repeat (50) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
            step();
        end
        chk("ovf_no_sixth_frame", bad, 0);
        chk("ovf_sticky_status", ReadData, 64'h0A);
        wr(STAT, 32'hFFFF_FFF7);
        rd(STAT);
        chk("ovf_no_clear_bit3_0", ReadData, 64'h0A);
        wr(STAT, 32'h8);
        rd(STAT);
        chk("ovf_cleared", ReadData, 64'h02);

        for (int i = 0; i < 10; i++) begin
            wr(BASE, {24'hFFFFFF, pat[i]});
            step();
            cap(0);
            chk($sformatf("wrap_frame_%0d", i), fr, ef(pat[i]));
        end
        rd(STAT);
        chk("wrap_status", ReadData, 64'h02);

        wr(BASE, 32'hA1);
        wr(BASE, 32'hA2);
        wr(BASE, 32'hA3);
        repeat (44) step();
        chk("mid_tx_before_reset", tx, 0);
        rd(STAT);
        chk("mid_status_before_reset", ReadData, 64'h14);
        reset = 1'b0;
        #1;
        chk("mid_tx_async", tx, 1);
        chk("mid_busy_in_reset", tx_busy, 0);
        chk("mid_status_in_reset", ReadData, 64'h02);
        step();
        step();
        reset = 1'b1;
        bad = 0;
        repeat (60) begin
            step();
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("mid_no_frame_after", bad, 0);
        chk("mid_status_after", ReadData, 64'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped 8N1 UART transmitter on the single-cycle ARM processor's data bus, downstream of `top`. It takes the processor's `MemWrite`, `DataAdr` and `WriteData` outputs. A write to its data register queues a byte in a small FIFO. A transmit state machine serialises the queued bytes onto `tx` at a fixed bit rate. The processor polls a status register through `ReadData`.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be at least 2.
- `FIFO_DEPTH`, default 4: number of byte entries; must be a power of 2, between 2 and 8.
- `BASE_ADDR`, default 32'h0000_0400: word-aligned base address of the register window.
- `clk`, input, 1 bit: system clock; all state changes on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset. A 0 clears all state immediately.
- `MemWrite`, input, 1 bit: processor store strobe, sampled on the rising edge of `clk`.
- `DataAdr`, input, 32 bits: processor data address.
- `WriteData`, input, 32 bits: processor store data.
- `ReadData`, output, 32 bits: combinational register read data for `DataAdr`.
- `tx`, output, 1 bit: serial line; idle level is 1.
- `tx_busy`, output, 1 bit: 1 while a frame is in progress or the FIFO is non-empty.

## Operation
- Register map; any address outside these two gives `ReadData`=0 and writes to it are ignored:
  - BASE+0, TXDATA, write-only, reads 0. A write pushes `WriteData[7:0]`; bits [31:8] are ignored.
  - BASE+4, STATUS:
    - Read: bit0 `full`, bit1 `empty`, bit2 `active` (FSM not IDLE), bit3 `overflow` (sticky), bits[7:4] `count`; all other bits 0.
    - Write with `WriteData[3]`=1 clears `overflow`. All other write bits are ignored.
- FIFO:
  - Circular buffer with read and write pointers of width log2(`FIFO_DEPTH`); pointers wrap modulo depth.
  - `count` is 0 to `FIFO_DEPTH`.
  - Push to TXDATA with count=`FIFO_DEPTH` and no pop in the same cycle: byte dropped, `overflow` set to 1, FIFO unchanged.
  - Push and pop in the same cycle: push accepted even when full; count unchanged.
  - Overflow set and STATUS clear in the same cycle cannot happen (different addresses).
- FSM states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head byte into an 8-bit shift register, load the baud counter with `CLKS_PER_BIT`-1, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA with bit index 0.
  - DATA: `tx`=shift register bit 0 (LSB first). Each time the baud counter reaches 0: shift right and increment the index. After the index-7 bit period, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end of the period:
    - FIFO non-empty: pop and go directly to START (no idle gap).
    - Otherwise: go to IDLE.
- `tx` is driven from a register (glitch-free).
- Baud counter: down-counter of width clog2(`CLKS_PER_BIT`). It reloads to `CLKS_PER_BIT`-1 on every bit boundary.

## Timing
- Reset values:
  - `tx`=1, `tx_busy`=0, FSM=IDLE, FIFO empty (count 0, both pointers 0), `overflow`=0.
  - `ReadData` while in reset = the STATUS value 32'h0000_0002 when `DataAdr`=BASE+4.
- Reset asserted mid-frame: `tx` returns to 1 asynchronously, the frame is aborted and queued bytes are discarded.
- Write accepted at rising edge k: FIFO non-empty and `tx_busy`=1 after edge k.
  - FSM idle: pop at edge k+1, `tx` falls after edge k+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- `ReadData` is combinational with zero latency. STATUS reflects the state registered at the last edge.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles, release, wait 50 cycles.
  - `tx`=1 and `tx_busy`=0 throughout.
  - STATUS read = 32'h0000_0002.
- Single byte (`CLKS_PER_BIT`=4): store 32'hFFFF_FF55 to BASE+0.
  - Starting one cycle after the write edge, `tx` shows 0, 1,0,1,0,1,0,1,0, 1 with 4 cycles per bit (40 cycles).
  - Then `tx_busy`=0.
- Back-to-back: store 0x41, 0x42, 0x43 on consecutive cycles.
  - Three contiguous 40-cycle frames with no idle cycle between stop and start.
  - STATUS `count` reads 2 right after the third write edge.
- Overflow (`FIFO_DEPTH`=4): store 6 bytes on consecutive cycles.
  - The first is popped into the FSM, the next 4 fill the FIFO, the 6th is dropped.
  - STATUS bit3=1 and bit0=1.
  - Exactly 5 frames are transmitted.
  - Storing 32'h8 to BASE+4 clears bit3.
- Pointer wrap: push 10 bytes spaced one frame apart.
  - All 10 bytes come out in order. `overflow` stays 0.
- Reset mid-frame: assert `reset`=0 during the DATA state of the second of two queued bytes.
  - `tx`=1 immediately. After release, FIFO is empty, no further frame is sent, and `overflow`=0.
